// File: rtl/spart_rx_if.sv
// spart_rx_if: serial-in / byte-out bundle between the SPART receiver and its bus side.
// Carries the shared 16x-baud tick, the raw serial line, the read strobe and the held byte with its flags.
// slave = receiver side; master = bus/baud side that drives enable, rxd and rd.
interface spart_rx_if #(
  parameter int DATA_W = 8
);
  logic              enable;
  logic              rxd;
  logic              rd;
  logic [DATA_W-1:0] rx_data;
  logic              rda;
  logic              frame_err;
  logic              overrun;

  modport master (
    output enable, rxd, rd,
    input  rx_data, rda, frame_err, overrun
  );

  modport slave (
    input  enable, rxd, rd,
    output rx_data, rda, frame_err, overrun
  );
endinterface

// File: rtl/spart_rx.sv
// spart_rx: 8N1 serial receiver, 16x oversampled on the shared baud enable tick, LSB first.
// Ports: clk, rst_n (async active-low), bus (slave: enable, rxd, rd in; rx_data, rda, frame_err, overrun out).
// Byte and flags are registered and update on the clk edge of the stop-bit sample; rd acknowledges the held byte.
module spart_rx #(
  parameter int DATA_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  spart_rx_if.slave   bus
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]        sync_q;
  logic              rxd_s;
  logic [1:0]        state_q, state_d;
  logic [3:0]        tick_q, tick_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              rda_q, rda_d;
  logic              fe_q, fe_d;
  logic              ov_q, ov_d;
  logic              done;

  // Two-flop synchronizer; idles high so reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], bus.rxd};
  end
  assign rxd_s = sync_q[1];

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    rda_d   = rda_q;
    fe_d    = fe_q;
    ov_d    = ov_q;
    done    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.enable && !rxd_s) begin
          state_d = START;
          tick_d  = 4'd0;
        end
      end
      START: begin
        if (bus.enable) begin
          tick_d = tick_q + 4'd1;
          // Mid start bit: a line that has gone high again was a glitch.
          if (tick_q == 4'd7) begin
            if (!rxd_s) begin
              state_d = DATA;
              tick_d  = 4'd0;
              bit_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      DATA: begin
        if (bus.enable) begin
          tick_d = tick_q + 4'd1;
          if (tick_q == 4'd15) begin
            shift_d = {rxd_s, shift_q[DATA_W-1:1]};
            bit_d   = bit_q + BW'(1);
            if (bit_q == BW'(DATA_W - 1)) begin
              state_d = STOP;
              tick_d  = 4'd0;
            end
          end
        end
      end
      STOP: begin
        if (bus.enable) begin
          tick_d = tick_q + 4'd1;
          // Back to IDLE at mid stop bit so a following start edge is not missed.
          if (tick_q == 4'd15) begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A completing byte beats a coincident read: the read acknowledged the
    // old byte, so the new one is fresh and not an overrun.
    if (done) begin
      data_d = shift_q;
      rda_d  = 1'b1;
      fe_d   = ~rxd_s;
      if (bus.rd)     ov_d = 1'b0;
      else if (rda_q) ov_d = 1'b1;
    end else if (bus.rd && rda_q) begin
      rda_d = 1'b0;
      fe_d  = 1'b0;
      ov_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tick_q  <= 4'd0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      rda_q   <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      rda_q   <= rda_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  assign bus.rx_data   = data_q;
  assign bus.rda       = rda_q;
  assign bus.frame_err = fe_q;
  assign bus.overrun   = ov_q;

endmodule

// File: tb/tb_spart_rx.sv
// tb_spart_rx: directed frames into spart_rx; expected bytes/flags go into a queue, a monitor compares on each new byte.
module tb_spart_rx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spart_rx_if #(.DATA_W(8)) bus ();

  spart_rx #(.DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       ov;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  logic       prev_rda = 1'b0;
  logic [7:0] prev_d   = 8'h00;
  logic       prev_fe  = 1'b0;
  logic       prev_ov  = 1'b0;
  exp_t       mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  task automatic push(input logic [7:0] d, input logic fe, input logic ov);
    exp_t e;
    e.d = d; e.fe = fe; e.ov = ov;
    exp_q.push_back(e);
  endtask

  // One bit time = 16 enable ticks = 16 clk with enable held high.
  task automatic bitn(input logic v);
    bus.rxd = v;
    repeat (16) @(negedge clk);
  endtask

  task automatic idle(input int n);
    bus.rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v);
    bitn(1'b0);
    for (int i = 0; i < 8; i++) bitn(d[i]);
    bitn(stop_v);
    bus.rxd = 1'b1;
  endtask

  task automatic pulse_rd();
    bus.rd = 1'b1;
    @(negedge clk);
    bus.rd = 1'b0;
  endtask

  // Monitor: a new byte shows up as rda rising or the held byte/flags changing while rda stays high.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.rda === 1'b1 &&
          (!prev_rda || bus.rx_data !== prev_d || bus.frame_err !== prev_fe || bus.overrun !== prev_ov)) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_byte: got %0h required none", bus.rx_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("rx_data",   {24'd0, bus.rx_data}, {24'd0, mon_e.d});
          check("frame_err", {31'd0, bus.frame_err}, {31'd0, mon_e.fe});
          check("overrun",   {31'd0, bus.overrun}, {31'd0, mon_e.ov});
        end
      end
      prev_rda = bus.rda;
      prev_d   = bus.rx_data;
      prev_fe  = bus.frame_err;
      prev_ov  = bus.overrun;
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: got running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.enable = 1'b1;
    bus.rxd    = 1'b1;
    bus.rd     = 1'b0;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rx_data",   {24'd0, bus.rx_data}, 32'h0);
    check("rst_rda",       {31'd0, bus.rda}, 32'h0);
    check("rst_frame_err", {31'd0, bus.frame_err}, 32'h0);
    check("rst_overrun",   {31'd0, bus.overrun}, 32'h0);
    rst_n = 1'b1;
    idle(10);

    // Case 1: plain frame, then acknowledge.
    push(8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b1);
    idle(4);
    check("c1_rda", {31'd0, bus.rda}, 32'h1);
    pulse_rd();
    check("c1_rda_after_rd", {31'd0, bus.rda}, 32'h0);

    // Case 2: short low glitch is rejected, then a real frame.
    bus.rxd = 1'b0;
    repeat (4) @(negedge clk);
    idle(30);
    check("c2_rda_glitch", {31'd0, bus.rda}, 32'h0);
    push(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1);
    idle(4);
    pulse_rd();

    // Case 3: stop bit low -> byte delivered with frame_err.
    push(8'h81, 1'b1, 1'b0);
    send_frame(8'h81, 1'b0);
    idle(40);
    check("c3_frame_err", {31'd0, bus.frame_err}, 32'h1);
    pulse_rd();
    check("c3_frame_err_after_rd", {31'd0, bus.frame_err}, 32'h0);
    check("c3_rda_after_rd", {31'd0, bus.rda}, 32'h0);

    // Case 4: back-to-back frames, no read -> overrun.
    push(8'h11, 1'b0, 1'b0);
    push(8'h22, 1'b0, 1'b1);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(4);
    check("c4_rx_data", {24'd0, bus.rx_data}, 32'h22);
    check("c4_overrun", {31'd0, bus.overrun}, 32'h1);
    pulse_rd();
    check("c4_rda_after_rd", {31'd0, bus.rda}, 32'h0);
    check("c4_fe_after_rd",  {31'd0, bus.frame_err}, 32'h0);
    check("c4_ov_after_rd",  {31'd0, bus.overrun}, 32'h0);

    // Case 5: rd coincides with the stop-sample edge of the second frame.
    // Start edge set at negedge N0; stop sample lands on the posedge after N154.
    push(8'hAA, 1'b0, 1'b0);
    send_frame(8'hAA, 1'b1);
    push(8'h55, 1'b0, 1'b0);
    fork
      send_frame(8'h55, 1'b1);
      begin
        repeat (154) @(negedge clk);
        bus.rd = 1'b1;
        @(negedge clk);
        bus.rd = 1'b0;
      end
    join
    idle(4);
    check("c5_rda",     {31'd0, bus.rda}, 32'h1);
    check("c5_rx_data", {24'd0, bus.rx_data}, 32'h55);
    check("c5_overrun", {31'd0, bus.overrun}, 32'h0);

    // Case 6: reset in the middle of 0xF0's data bits.
    bitn(1'b0);
    bitn(1'b0);
    bitn(1'b0);
    bitn(1'b0);
    bus.rxd = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("c6_rst_rx_data",   {24'd0, bus.rx_data}, 32'h0);
    check("c6_rst_rda",       {31'd0, bus.rda}, 32'h0);
    check("c6_rst_frame_err", {31'd0, bus.frame_err}, 32'h0);
    check("c6_rst_overrun",   {31'd0, bus.overrun}, 32'h0);
    bus.rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(20);
    push(8'h0F, 1'b0, 1'b0);
    send_frame(8'h0F, 1'b1);
    idle(4);
    check("c6_rda", {31'd0, bus.rda}, 32'h1);

    idle(5);
    check("all_bytes_seen", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
